// File: rtl/flow_pkg.sv
// Shared types and constants for the flow valve sequencer and its command queue.
package flow_pkg;

    // Valve vector geometry and dwell counter width
    localparam int N_VALVES = 4;
    localparam int DWELL_W  = 16;

    // Bit positions of each solenoid inside valve_en / cmd_mask
    localparam int V_SOLN1 = 0;
    localparam int V_SOLN2 = 1;
    localparam int V_SOLN3 = 2;
    localparam int V_OUT   = 3;

    // One queued step: which valves to open and for how many cycles
    typedef struct packed {
        logic [N_VALVES-1:0] mask;
        logic [DWELL_W-1:0]  dwell;
    } flow_cmd_t;

    // Sequencer phases; prefixed so they never collide with the GUARD parameter
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_GUARD
    } flow_state_t;

endpackage

// File: rtl/flow_cmd_fifo.sv
// Show-ahead synchronous FIFO of sequencer steps with a single-cycle flush.
// DEPTH must be a power of two (>= 2) so the pointers wrap by plain overflow.
module flow_cmd_fifo
    import flow_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  flow_cmd_t wr_data,
    output flow_cmd_t rd_data,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    flow_cmd_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    // A push into a full queue is legal when a pop frees a slot in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/flow_valve_sequencer.sv
// Timed solenoid sequencer: pops queued {mask, dwell} steps, opens the mask for
// dwell cycles, then holds every valve closed for GUARD cycles before the next step.
module flow_valve_sequencer
    import flow_pkg::*;
#(
    parameter int N_INLETS   = 3,
    parameter int GUARD      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [N_VALVES-1:0] cmd_mask,
    input  logic [DWELL_W-1:0]  cmd_dwell,
    input  logic                abort,
    output logic [N_VALVES-1:0] valve_en,
    output logic                busy,
    output logic                step_done,
    output logic                err_illegal,
    output logic [15:0]         step_count
);
    localparam int   GW        = $clog2(GUARD + 1);
    localparam logic GUARD_ONE = (GUARD == 1);

    flow_state_t        state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [GW-1:0]      guard_cnt;
    flow_cmd_t          wr_cmd;
    flow_cmd_t          head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               illegal;
    logic               push;
    logic               pop;
    logic               guard_last;

    // True when two or more solution inlets would be opened together
    function automatic logic inlet_conflict(input logic [N_VALVES-1:0] m);
        logic [N_INLETS-1:0] inl;
        inl = m[N_INLETS-1:0];
        return (inl & (inl - N_INLETS'(1))) != '0;
    endfunction

    // Illegal commands are still handshaken so the host never stalls on them
    assign cmd_ready  = !fifo_full;
    assign accept     = cmd_valid && cmd_ready && !abort;
    assign illegal    = inlet_conflict(cmd_mask);
    assign push       = accept && !illegal;
    assign wr_cmd     = '{mask: cmd_mask, dwell: cmd_dwell};
    assign guard_last = (state == ST_GUARD) && (guard_cnt == GW'(1));
    assign pop        = !abort && !fifo_empty && ((state == ST_IDLE) || guard_last);
    assign busy       = !fifo_empty || (state != ST_IDLE);

    flow_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (abort),
        .wr_data (wr_cmd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Step FSM with registered valve enables, done pulse, step counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            valve_en    <= '0;
            dwell_cnt   <= '0;
            guard_cnt   <= '0;
            step_done   <= 1'b0;
            step_count  <= '0;
            err_illegal <= 1'b0;
        end else begin
            step_done <= 1'b0;
            if (accept && illegal) begin
                err_illegal <= 1'b1;
            end
            if (abort) begin
                state     <= ST_IDLE;
                valve_en  <= '0;
                dwell_cnt <= '0;
                guard_cnt <= '0;
            end else begin
                case (state)
                    ST_OPEN: begin
                        if (dwell_cnt == DWELL_W'(1)) begin
                            valve_en   <= '0;
                            state      <= ST_GUARD;
                            guard_cnt  <= GW'(GUARD);
                            step_done  <= GUARD_ONE;
                            step_count <= step_count + 16'(GUARD_ONE);
                        end else begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end
                    end
                    ST_GUARD: begin
                        guard_cnt <= guard_cnt - GW'(1);
                        // Raise done so it is visible during the final guard cycle
                        if (guard_cnt == GW'(2)) begin
                            step_done  <= 1'b1;
                            step_count <= step_count + 16'd1;
                        end
                        if (guard_last) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
                // A pop starts the next step and overrides the return to IDLE
                if (pop) begin
                    if (head.dwell != '0) begin
                        state     <= ST_OPEN;
                        valve_en  <= head.mask;
                        dwell_cnt <= head.dwell;
                    end else begin
                        state      <= ST_GUARD;
                        guard_cnt  <= GW'(GUARD);
                        step_done  <= GUARD_ONE;
                        step_count <= step_count + 16'(GUARD_ONE);
                    end
                end
            end
        end
    end

endmodule
